// File: rtl/stopwatch_scan_ctrl.sv
// rtl/stopwatch_scan_ctrl.sv - multiplexed six-digit stopwatch display scanner with lap snapshot
module stopwatch_scan_ctrl #(
    parameter int SCAN_DIV  = 10000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd_in,
    input  logic        lap,
    input  logic        lap_clr,
    input  logic        blank_en,
    output logic [3:0]  dec_a,
    output logic        dec_dot,
    output logic [5:0]  digit_sel,
    output logic        frozen
);

    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} scan_state_t;
    typedef enum logic {SN_LIVE, SN_FROZEN} snap_state_t;

    scan_state_t   r_state;
    snap_state_t   r_snap_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [23:0]   r_snap;
    logic [3:0]    r_dec_a;
    logic          r_dec_dot;
    logic [5:0]    r_digit_sel;
    logic          r_frozen;

    logic [23:0]   w_src;
    logic [3:0]    w_digit;
    logic          w_blank;
    logic          w_dot;
    logic [5:0]    w_sel;

    // Pick the digit source, the current digit and its blank/dot decoration
    always_comb begin
        w_src   = (r_snap_state == SN_FROZEN) ? r_snap : bcd_in;
        w_digit = w_src[3:0];
        case (r_idx)
            3'd0:    w_digit = w_src[3:0];
            3'd1:    w_digit = w_src[7:4];
            3'd2:    w_digit = w_src[11:8];
            3'd3:    w_digit = w_src[15:12];
            3'd4:    w_digit = w_src[19:16];
            3'd5:    w_digit = w_src[23:20];
            default: w_digit = w_src[3:0];
        endcase
        w_blank = blank_en &&
                  (((r_idx == 3'd5) && (w_src[23:20] == 4'd0)) ||
                   ((r_idx == 3'd4) && (w_src[23:16] == 8'd0)));
        w_dot   = (r_idx == 3'd2) || (r_idx == 3'd4);
        w_sel   = ~(6'b000001 << r_idx);
    end

    // Scan FSM: alternate BLANK and SHOW phases, stepping through digits 0..5
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BLANK;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_dec_a     <= 4'd0;
            r_dec_dot   <= 1'b0;
            r_digit_sel <= 6'b111111;
        end else begin
            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= '0;
                        r_dec_a <= w_digit;
                        if (w_blank) begin
                            r_digit_sel <= 6'b111111;
                            r_dec_dot   <= 1'b0;
                        end else begin
                            r_digit_sel <= w_sel;
                            r_dec_dot   <= w_dot;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        r_state     <= ST_BLANK;
                        r_cnt       <= '0;
                        r_digit_sel <= 6'b111111;
                        r_dec_dot   <= 1'b0;
                        r_idx       <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Lap FSM: lap captures a snapshot, lap_clr returns to live and takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_state <= SN_LIVE;
            r_frozen     <= 1'b0;
            r_snap       <= 24'd0;
        end else begin
            if (lap_clr) begin
                r_snap_state <= SN_LIVE;
                r_frozen     <= 1'b0;
            end else if (lap) begin
                r_snap_state <= SN_FROZEN;
                r_frozen     <= 1'b1;
                r_snap       <= bcd_in;
            end
        end
    end

    assign dec_a     = r_dec_a;
    assign dec_dot   = r_dec_dot;
    assign digit_sel = r_digit_sel;
    assign frozen    = r_frozen;

endmodule

// File: tb/tb_stopwatch_scan_ctrl.sv
// tb/tb_stopwatch_scan_ctrl.sv - self-checking bench for stopwatch_scan_ctrl
module tb_stopwatch_scan_ctrl;

    localparam int SD   = 4;
    localparam int BC   = 2;
    localparam int SLOT = SD + BC;
    localparam int PER  = 6 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] bcd_in;
    logic        lap;
    logic        lap_clr;
    logic        blank_en;
    logic [3:0]  dec_a;
    logic        dec_dot;
    logic [5:0]  digit_sel;
    logic        frozen;

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;

    int          m_k;
    logic        m_frozen;
    logic [23:0] m_snap;
    logic [3:0]  m_val;
    logic        m_blk;

    always #5 clk = ~clk;

    stopwatch_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_in    (bcd_in),
        .lap       (lap),
        .lap_clr   (lap_clr),
        .blank_en  (blank_en),
        .dec_a     (dec_a),
        .dec_dot   (dec_dot),
        .digit_sel (digit_sel),
        .frozen    (frozen)
    );

    function automatic logic [3:0] digit_of(input logic [23:0] v, input int i);
        return v[i*4 +: 4];
    endfunction

    function automatic logic is_blanked(input logic [23:0] v, input int i, input logic en);
        return en && (((i == 5) && (v[23:20] == 4'd0)) || ((i == 4) && (v[23:16] == 8'd0)));
    endfunction

    function automatic logic [5:0] sel_for(input int i);
        logic [5:0] s;
        s = 6'b111111;
        s[i] = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Model: position in the 36-clock scan frame follows from edges since reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k      <= 0;
            m_frozen <= 1'b0;
            m_snap   <= 24'd0;
            m_val    <= 4'd0;
            m_blk    <= 1'b0;
        end else begin
            if (((m_k + 1) % SLOT) == BC) begin
                m_val <= digit_of(m_frozen ? m_snap : bcd_in, ((m_k + 1) % PER) / SLOT);
                m_blk <= is_blanked(m_frozen ? m_snap : bcd_in, ((m_k + 1) % PER) / SLOT, blank_en);
            end
            if (lap_clr) begin
                m_frozen <= 1'b0;
            end else if (lap) begin
                m_frozen <= 1'b1;
                m_snap   <= bcd_in;
            end
            m_k <= m_k + 1;
        end
    end

    // Compare DUT against the model every cycle, mid-way between rising edges
    always @(negedge clk) begin
        int  p;
        int  idx;
        bit  lit_on;
        if (run) begin
            p      = m_k % PER;
            idx    = p / SLOT;
            lit_on = ((p % SLOT) >= BC) && !m_blk;
            chk("model_sel", digit_sel, lit_on ? sel_for(idx) : 6'b111111);
            chk("model_dot", dec_dot, lit_on && ((idx == 2) || (idx == 4)));
            chk("model_frozen", frozen, m_frozen);
            if (lit_on)
                chk("model_dec_a", dec_a, m_val);
            if (!rst_n)
                chk("model_rst_dec_a", dec_a, 4'd0);
        end
    end

    initial begin
        rst_n    = 1'b0;
        bcd_in   = 24'd0;
        lap      = 1'b0;
        lap_clr  = 1'b0;
        blank_en = 1'b0;
        edges(2);
        chk("rst_sel", digit_sel, 6'h3f);
        chk("rst_a", dec_a, 4'd0);
        chk("rst_dot", dec_dot, 1'b0);
        chk("rst_frozen", frozen, 1'b0);
        run = 1'b1;

        // Basic scan, no blanking
        bcd_in = 24'h012345;
        do_reset();
        chk("s1_k0_sel", digit_sel, 6'h3f);
        edges(1); chk("s1_k1_sel", digit_sel, 6'h3f);
        edges(1); chk("s1_k2_sel", digit_sel, 6'h3e); chk("s1_k2_a", dec_a, 4'd5); chk("s1_k2_dot", dec_dot, 1'b0);
        edges(3); chk("s1_k5_sel", digit_sel, 6'h3e);
        edges(1); chk("s1_k6_sel", digit_sel, 6'h3f);
        edges(2); chk("s1_k8_sel", digit_sel, 6'h3d); chk("s1_k8_a", dec_a, 4'd4);
        edges(6); chk("s1_k14_sel", digit_sel, 6'h3b); chk("s1_k14_a", dec_a, 4'd3); chk("s1_k14_dot", dec_dot, 1'b1);
        edges(6); chk("s1_k20_sel", digit_sel, 6'h37); chk("s1_k20_a", dec_a, 4'd2); chk("s1_k20_dot", dec_dot, 1'b0);
        edges(6); chk("s1_k26_sel", digit_sel, 6'h2f); chk("s1_k26_a", dec_a, 4'd1); chk("s1_k26_dot", dec_dot, 1'b1);
        edges(6); chk("s1_k32_sel", digit_sel, 6'h1f); chk("s1_k32_a", dec_a, 4'd0);
        edges(6); chk("s1_k38_sel", digit_sel, 6'h3e); chk("s1_k38_a", dec_a, 4'd5);

        // Leading-zero blanking of digits 5 and 4
        bcd_in = 24'h000123; blank_en = 1'b1;
        do_reset();
        edges(26); chk("s2_k26_sel", digit_sel, 6'h3f); chk("s2_k26_dot", dec_dot, 1'b0);
        edges(6);  chk("s2_k32_sel", digit_sel, 6'h3f);
        edges(6);  chk("s2_k38_sel", digit_sel, 6'h3e); chk("s2_k38_a", dec_a, 4'd3);

        // Digit 4 non-zero keeps it lit while digit 5 blanks
        bcd_in = 24'h050000;
        do_reset();
        edges(26); chk("s3_k26_sel", digit_sel, 6'h2f); chk("s3_k26_a", dec_a, 4'd5); chk("s3_k26_dot", dec_dot, 1'b1);
        edges(6);  chk("s3_k32_sel", digit_sel, 6'h3f); chk("s3_k32_dot", dec_dot, 1'b0);
        edges(6);  chk("s3_k38_sel", digit_sel, 6'h3e); chk("s3_k38_a", dec_a, 4'd0);

        // Non-decimal codes pass through unchanged
        bcd_in = 24'h0FEDCB;
        do_reset();
        edges(26); chk("s4_k26_a", dec_a, 4'hf); chk("s4_k26_sel", digit_sel, 6'h2f);
        edges(6);  chk("s4_k32_sel", digit_sel, 6'h3f);
        edges(6);  chk("s4_k38_a", dec_a, 4'hb);

        // Lap snapshot, then release
        bcd_in = 24'h012345; blank_en = 1'b0;
        do_reset();
        edges(3); lap = 1'b1;
        edges(1); lap = 1'b0; bcd_in = 24'h999999;
        chk("s5_frozen_set", frozen, 1'b1);
        edges(4);  chk("s5_k8_a", dec_a, 4'd4); chk("s5_k8_sel", digit_sel, 6'h3d);
        edges(30); chk("s5_k38_a", dec_a, 4'd5);
        edges(12); lap_clr = 1'b1;
        edges(1);  lap_clr = 1'b0;
        chk("s5_frozen_clr", frozen, 1'b0);
        edges(5);  chk("s5_k56_a", dec_a, 4'd9); chk("s5_k56_sel", digit_sel, 6'h37);

        // lap and lap_clr together: lap_clr wins in both states
        lap = 1'b1; lap_clr = 1'b1;
        edges(1); lap = 1'b0; lap_clr = 1'b0;
        chk("s6_live_both", frozen, 1'b0);
        lap = 1'b1;
        edges(1); lap = 1'b0;
        chk("s6_lap", frozen, 1'b1);
        bcd_in = 24'h111111; blank_en = 1'b1;
        lap = 1'b1; lap_clr = 1'b1;
        edges(1); lap = 1'b0; lap_clr = 1'b0;
        chk("s6_frozen_both", frozen, 1'b0);
        edges(20);
        blank_en = 1'b0;
        edges(20);

        // Asynchronous reset in the middle of digit 3's SHOW slot
        bcd_in = 24'h012345;
        do_reset();
        edges(10); lap = 1'b1;
        edges(1);  lap = 1'b0;
        edges(10); chk("s7_k21_sel", digit_sel, 6'h37); chk("s7_k21_a", dec_a, 4'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("s7_async_sel", digit_sel, 6'h3f);
        chk("s7_async_a", dec_a, 4'd0);
        chk("s7_async_dot", dec_dot, 1'b0);
        chk("s7_async_frozen", frozen, 1'b0);
        @(posedge clk); #2; rst_n = 1'b1;
        chk("s7_k0_sel", digit_sel, 6'h3f);
        edges(1); chk("s7_k1_sel", digit_sel, 6'h3f);
        edges(1); chk("s7_k2_sel", digit_sel, 6'h3e); chk("s7_k2_a", dec_a, 4'd5);
        edges(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
